aq_djpeg_fb_writer: RTL

//  Downstream of the YCbCr->RGB stage. Accepts decoded RGB pixels (block/MCU order, with X/Y),

---
 rtl/aq_djpeg_fb_writer_pkg.sv | 21 ++
 rtl/aq_djpeg_fb_fifo.sv | 76 +++++++
 rtl/aq_djpeg_fb_writer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/aq_djpeg_fb_writer_pkg.sv
// Shared definitions for the JPEG framebuffer writer: FSM encodings,
// write-request layout and the pixel packing helper.
package aq_djpeg_fb_writer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_req_t;

    function automatic logic [31:0] pack_pixel(input logic [7:0] r,
                                               input logic [7:0] g,
                                               input logic [7:0] b);
        return {8'h00, r, g, b};
    endfunction

endpackage

// File: rtl/aq_djpeg_fb_fifo.sv
// Synchronous write-request FIFO with flush; a push into a full FIFO is
// only taken when a pop frees a slot in the same cycle.
module aq_djpeg_fb_fifo
    import aq_djpeg_fb_writer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  wr_req_t                push_data,
    input  logic                   pop,
    output wr_req_t                pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    wr_req_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    // Pointer and occupancy update; flush wins over any push/pop.
    always_comb begin
        pop_ok_s  = pop && (count_q != {(AW + 1){1'b0}});
        push_ok_s = push && ((count_q != FULL_CNT) || pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW + 1){1'b0}};
        end else begin
            wr_ptr_d = push_ok_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            rd_ptr_d = pop_ok_s  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            count_d  = count_q + (AW + 1)'(push_ok_s) - (AW + 1)'(pop_ok_s);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head reads zero until first write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{addr: 32'd0, data: 32'd0};
            end
        end else if (push_ok_s && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == {(AW + 1){1'b0}});
    assign free     = FULL_CNT - count_q;

endmodule

// File: rtl/aq_djpeg_fb_writer.sv
// Framebuffer writer: clips decoded RGB pixels to the image, computes byte
// addresses in a two-stage pipeline and queues write requests for the master.
module aq_djpeg_fb_writer
    import aq_djpeg_fb_writer_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int READY_MARGIN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ProcessInit,
    input  logic [15:0] ImageWidth,
    input  logic [15:0] ImageHeight,
    input  logic [31:0] FrameBase,
    input  logic [15:0] LineStride,
    input  logic        InEnable,
    input  logic [15:0] InPixelX,
    input  logic [15:0] InPixelY,
    input  logic [7:0]  InR,
    input  logic [7:0]  InG,
    input  logic [7:0]  InB,
    output logic        InReady,
    output logic        WrValid,
    input  logic        WrReady,
    output logic [31:0] WrAddr,
    output logic [31:0] WrData,
    output logic        Busy,
    output logic        FrameDone,
    output logic        Overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    state_q, state_d;
    logic [15:0]   w_q, w_d, h_q, h_d, stride_q, stride_d;
    logic [31:0]   base_q, base_d, wh_q, wh_d, cnt_q, cnt_d;
    logic          s1_valid_q, s1_valid_d;
    logic [31:0]   s1_prod_q, s1_prod_d, s1_xoff_q, s1_xoff_d, s1_data_q, s1_data_d;
    logic          s2_valid_q, s2_valid_d;
    logic [31:0]   s2_addr_q, s2_addr_d, s2_data_q, s2_data_d;
    logic          overflow_q, overflow_d, busy_q, busy_d, frame_done_q, frame_done_d;

    logic          in_take_s, push_s, pop_s, drop_s, in_ready_s;
    logic [1:0]    occ_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [CW-1:0] fifo_free_s;
    wr_req_t       fifo_in_s, fifo_out_s;

    // Frame configuration is captured only at ProcessInit.
    always_comb begin
        w_d      = w_q;
        h_d      = h_q;
        base_d   = base_q;
        stride_d = stride_q;
        wh_d     = wh_q;
        if (ProcessInit) begin
            w_d      = ImageWidth;
            h_d      = ImageHeight;
            base_d   = FrameBase;
            stride_d = LineStride;
            wh_d     = 32'(ImageWidth) * 32'(ImageHeight);
        end else begin
            wh_d     = wh_q;
        end
    end

    // Clip, then S1 multiplies the row offset and S2 forms the final address.
    always_comb begin
        in_take_s = (state_q == ST_RUN) && InEnable &&
                    (InPixelX < w_q) && (InPixelY < h_q);
        s1_prod_d = 32'(InPixelY) * 32'(stride_q);
        s1_xoff_d = {14'd0, InPixelX, 2'b00};
        s1_data_d = pack_pixel(InR, InG, InB);
        s2_addr_d = base_q + s1_prod_q + s1_xoff_q;
        s2_data_d = s1_data_q;
        if (ProcessInit) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            s1_valid_d = in_take_s;
            s2_valid_d = s1_valid_q;
        end
    end

    // FIFO handshake; a dropped pixel still counts so the frame can finish.
    always_comb begin
        pop_s  = !fifo_empty_s && WrReady;
        push_s = s2_valid_q && !ProcessInit;
        drop_s = push_s && fifo_full_s && !pop_s;
        if (ProcessInit) begin
            cnt_d      = 32'd0;
            overflow_d = 1'b0;
        end else begin
            cnt_d      = cnt_q + {31'd0, push_s};
            overflow_d = overflow_q || drop_s;
        end
    end

    // Upstream throttle: keep READY_MARGIN slots spare beyond in-flight pixels.
    always_comb begin
        occ_s      = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
        in_ready_s = (state_q == ST_RUN) &&
                     ((CW + 1)'(fifo_free_s) >= (CW + 1)'(occ_s) + (CW + 1)'(READY_MARGIN));
    end

    // Frame FSM; ProcessInit restarts from any state.
    always_comb begin
        state_d = state_q;
        if (ProcessInit) begin
            if ((ImageWidth == 16'd0) || (ImageHeight == 16'd0)) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_RUN: begin
                    if (cnt_q >= wh_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid_q && !s2_valid_q && fifo_empty_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
        busy_d       = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        frame_done_d = (state_q == ST_DONE) && !ProcessInit;
    end

    // State, configuration and pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            w_q          <= 16'd0;
            h_q          <= 16'd0;
            stride_q     <= 16'd0;
            base_q       <= 32'd0;
            wh_q         <= 32'd0;
            cnt_q        <= 32'd0;
            s1_valid_q   <= 1'b0;
            s1_prod_q    <= 32'd0;
            s1_xoff_q    <= 32'd0;
            s1_data_q    <= 32'd0;
            s2_valid_q   <= 1'b0;
            s2_addr_q    <= 32'd0;
            s2_data_q    <= 32'd0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            h_q          <= h_d;
            stride_q     <= stride_d;
            base_q       <= base_d;
            wh_q         <= wh_d;
            cnt_q        <= cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_prod_q    <= s1_prod_d;
            s1_xoff_q    <= s1_xoff_d;
            s1_data_q    <= s1_data_d;
            s2_valid_q   <= s2_valid_d;
            s2_addr_q    <= s2_addr_d;
            s2_data_q    <= s2_data_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fifo_in_s = {s2_addr_q, s2_data_q};

    aq_djpeg_fb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (ProcessInit),
        .push     (push_s),
        .push_data(fifo_in_s),
        .pop      (pop_s),
        .pop_data (fifo_out_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .free     (fifo_free_s)
    );

    assign InReady   = in_ready_s;
    assign WrValid   = !fifo_empty_s;
    assign WrAddr    = fifo_out_s.addr;
    assign WrData    = fifo_out_s.data;
    assign Busy      = busy_q;
    assign FrameDone = frame_done_q;
    assign Overflow  = overflow_q;

endmodule
